color_event_arbiter: RTL and testbench
======================================

Name: color_event_arbiter

Overview:
- Monitors NCH independent RGB color-sense channels and detects per-channel color changes.
- Changes are queued as one pending event per channel.
- Queued events are shared round-robin onto a single valid/ready output port feeding a downstream logger/display driver.
- Acts as the scheduler that lets several color-change detectors share one event consumer.

Parameters:
NCH, 4, number of color-sense channels (2..16)
CHW, 2, width of Out_Chan; must be >= clog2(NCH)

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
Red  input  NCH  per-channel red sense bit
Green  input  NCH  per-channel green sense bit
Blue  input  NCH  per-channel blue sense bit
Out_Ready  input  1  consumer accepts event this cycle
Out_Valid  output  1  event offered on Out_Chan/Out_Color
Out_Chan  output  CHW  channel index of offered event
Out_Color  output  2  new color code of offered event
Busy  output  1  high when any Pending bit is set or Out_Valid is high
Overrun  output  NCH  sticky per-channel lost-event flag

Behaviour:
- Reset values: Out_Valid=0, Out_Chan=0, Out_Color=2'b11, Overrun=0, Busy=0, all LastColor=2'b11 (White), Pending=0, round-robin pointer Ptr=0, FSM=IDLE.
- Color encoding: Red=00, Green=01, Blue=10, White=11.
- Per-channel decode priority: Red > Green > Blue; no bit set decodes to White.
- Change detect: for channel i, Chg[i] = (decoded color != LastColor[i]). On each edge with Chg[i]=1:
  - LastColor[i] and PendColor[i] <= decoded color.
  - Pending[i] <= 1.
- Overrun: Chg[i]=1 while Pending[i]=1 and channel i is not granted that same cycle.
  - Overwrites PendColor[i] (newest wins) and sets Overrun[i].
  - Overrun[i] clears only on Reset.
- FSM has two states:
  - IDLE: if any Pending bit is set, grant the first set channel searching from Ptr upward with wrap at NCH-1 -> 0. On the same edge:
    - Out_Chan <= i, Out_Color <= PendColor[i], Out_Valid <= 1, Pending[i] <= 0, FSM -> OFFER.
    - If Chg[i]=1 on that same edge, Pending[i] stays 1 with the new color and no overrun is flagged.
  - OFFER: Out_Valid, Out_Chan and Out_Color are held stable until Out_Ready=1.
    - On the handshake edge: Out_Valid <= 0, Ptr <= (Out_Chan+1) mod NCH, FSM -> IDLE.
    - Out_Ready while in IDLE is ignored.
- Latency: input change sampled at edge t -> Pending at t -> Out_Valid high after edge t+1.
- Throughput: at most one event per 2 cycles.
- Changes arriving during OFFER, including on the offered channel, are queued normally.
- Simultaneous changes on several channels in one cycle all set Pending; they are served in round-robin order.
- Reset asserted mid-OFFER drops the offered event immediately; all state returns to reset values.

Optional Feature:
COLOR_DROP_CNT_EN
- Defined:
  - Adds output port Drop_Count [7:0], reset 0.
  - Each edge it adds the number of channels raising an overrun that cycle, saturating at 255.
  - Holds at 255 until Reset.
- Undefined: port and counter are absent; Overrun flags behave identically.

Test Plan:
- Reset, all inputs 0 -> Out_Valid=0, Out_Color=11, Busy=0; no events ever produced.
- Ch1 Red=1 at cycle 5, Out_Ready=1 -> Out_Valid high one cycle later with Out_Chan=1, Out_Color=00; handshake next edge; Ptr=2.
- Ch0, ch2, ch3 change simultaneously with Ptr=2, Out_Ready=1 -> events emitted in order ch2, ch3, ch0, each 2 cycles apart.
- Ch0 Red then Green on consecutive cycles while Out_Ready=0 and ch0 is already pending behind another offered event -> Overrun[0]=1; only the Green (01) event is later delivered; Drop_Count=1 when COLOR_DROP_CNT_EN is defined.
- Out_Ready held 0 for 10 cycles during OFFER -> Out_Valid, Out_Chan and Out_Color stable the entire time; accepted on the first cycle Out_Ready=1.
- Reset pulsed mid-OFFER with pending events -> Out_Valid=0, Pending=0, Overrun=0, Busy=0 asynchronously; no stale event after release.

Source files
------------

// File: rtl/color_event_arbiter.sv
// Color-change detector for NCH RGB sense channels; one pending event per channel, served round-robin on a valid/ready port.
// Optional build macro COLOR_DROP_CNT_EN adds an 8-bit saturating Drop_Count of lost (overrun) events.
module color_event_arbiter #(
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic [NCH-1:0] Red,
    input  logic [NCH-1:0] Green,
    input  logic [NCH-1:0] Blue,
    input  logic           Out_Ready,
    output logic           Out_Valid,
    output logic [CHW-1:0] Out_Chan,
    output logic [1:0]     Out_Color,
    output logic           Busy,
    output logic [NCH-1:0] Overrun
`ifdef COLOR_DROP_CNT_EN
    ,
    output logic [7:0]     Drop_Count
`endif
);

    // Handshake: an event transfers on a rising edge where Out_Valid && Out_Ready;
    // while Out_Valid is high, Out_Chan/Out_Color hold stable until that edge.
    typedef enum logic {IDLE, OFFER} state_t;

    state_t         state, state_nxt;
    logic [1:0]     color      [NCH];
    logic [1:0]     last_color [NCH];
    logic [1:0]     pend_color [NCH];
    logic [NCH-1:0] pending;
    logic [NCH-1:0] chg;
    logic [NCH-1:0] grant_oh;
    logic [NCH-1:0] ovr_evt;
    logic           grant;
    logic [CHW-1:0] grant_idx;
    logic [CHW-1:0] ptr;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            if (Red[i])        color[i] = 2'b00;
            else if (Green[i]) color[i] = 2'b01;
            else if (Blue[i])  color[i] = 2'b10;
            else               color[i] = 2'b11;
            chg[i] = (color[i] != last_color[i]);
        end
    end

    // Walk downward so the channel closest to ptr (smallest offset) is written last and wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = 1'b0;
        grant_idx = '0;
        if (state == IDLE) begin
            for (int k = NCH - 1; k >= 0; k--) begin
                idx = (int'(ptr) + k) % NCH;
                if (pending[idx]) begin
                    grant     = 1'b1;
                    grant_idx = CHW'(idx);
                end
            end
        end
    end

    assign grant_oh = grant ? (NCH'(1) << grant_idx) : '0;
    // A change on the channel being granted refills its slot instead of counting as lost.
    assign ovr_evt  = chg & pending & ~grant_oh;
    assign Busy     = (|pending) | Out_Valid;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant)     state_nxt = OFFER;
            OFFER:   if (Out_Ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NCH; i++) begin
                last_color[i] <= 2'b11;
                pend_color[i] <= 2'b11;
            end
            pending   <= '0;
            Overrun   <= '0;
            Out_Valid <= 1'b0;
            Out_Chan  <= '0;
            Out_Color <= 2'b11;
            ptr       <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (chg[i]) begin
                    last_color[i] <= color[i];
                    pend_color[i] <= color[i];
                end
            end
            pending <= (pending & ~grant_oh) | chg;
            Overrun <= Overrun | ovr_evt;
            if (grant) begin
                Out_Valid <= 1'b1;
                Out_Chan  <= grant_idx;
                Out_Color <= pend_color[grant_idx];
            end else if (state == OFFER && Out_Ready) begin
                Out_Valid <= 1'b0;
                ptr       <= (Out_Chan == CHW'(NCH - 1)) ? '0 : Out_Chan + CHW'(1);
            end
        end
    end

`ifdef COLOR_DROP_CNT_EN
    logic [8:0] drop_sum;

    always_comb begin
        drop_sum = {1'b0, Drop_Count};
        for (int i = 0; i < NCH; i++) drop_sum = drop_sum + 9'(ovr_evt[i]);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) Drop_Count <= '0;
        else       Drop_Count <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    end
`endif

endmodule

// File: tb/tb_color_event_arbiter.sv
// Directed bench for color_event_arbiter: vector table for the main flow, then hand sequences
// for ready back-pressure, overrun and asynchronous reset during an offer.
module tb_color_event_arbiter;

    logic       Clock;
    logic       Reset;
    logic [3:0] Red, Green, Blue;
    logic       Out_Ready;
    logic       Out_Valid;
    logic [1:0] Out_Chan;
    logic [1:0] Out_Color;
    logic       Busy;
    logic [3:0] Overrun;
`ifdef COLOR_DROP_CNT_EN
    logic [7:0] Drop_Count;
`endif

    int passed = 0;
    int total  = 0;

    color_event_arbiter #(.NCH(4), .CHW(2)) dut (
        .Clock(Clock), .Reset(Reset),
        .Red(Red), .Green(Green), .Blue(Blue),
        .Out_Ready(Out_Ready), .Out_Valid(Out_Valid),
        .Out_Chan(Out_Chan), .Out_Color(Out_Color),
        .Busy(Busy), .Overrun(Overrun)
`ifdef COLOR_DROP_CNT_EN
        , .Drop_Count(Drop_Count)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [3:0] red, green, blue;
        logic       rdy;
        logic       valid;
        logic [1:0] chan, color;
        logic       busy;
        logic [3:0] ovr;
    } vec_t;

    vec_t vecs[14];

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_port(input string tag, input logic v, input logic [1:0] ch,
                            input logic [1:0] col, input logic b, input logic [3:0] ov);
        chk({tag, " valid"}, 32'(Out_Valid), 32'(v));
        chk({tag, " chan"}, 32'(Out_Chan), 32'(ch));
        chk({tag, " color"}, 32'(Out_Color), 32'(col));
        chk({tag, " busy"}, 32'(Busy), 32'(b));
        chk({tag, " overrun"}, 32'(Overrun), 32'(ov));
    endtask

    initial begin
        // {red, green, blue, rdy, exp valid, chan, color, busy, overrun} after the edge
        vecs[0]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 2'b11, 1'b0, 4'b0000};
        vecs[1]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 2'b11, 1'b0, 4'b0000};
        vecs[2]  = '{4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 2'b11, 1'b1, 4'b0000};
        vecs[3]  = '{4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd1, 2'b00, 1'b1, 4'b0000};
        vecs[4]  = '{4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd1, 2'b00, 1'b0, 4'b0000};
        vecs[5]  = '{4'b1110, 4'b0000, 4'b0001, 1'b1, 1'b0, 2'd1, 2'b00, 1'b1, 4'b0000};
        vecs[6]  = '{4'b1110, 4'b0000, 4'b0001, 1'b1, 1'b1, 2'd2, 2'b00, 1'b1, 4'b0000};
        vecs[7]  = '{4'b1110, 4'b0000, 4'b0001, 1'b1, 1'b0, 2'd2, 2'b00, 1'b1, 4'b0000};
        vecs[8]  = '{4'b1110, 4'b0000, 4'b0001, 1'b1, 1'b1, 2'd3, 2'b00, 1'b1, 4'b0000};
        vecs[9]  = '{4'b1110, 4'b0000, 4'b0001, 1'b1, 1'b0, 2'd3, 2'b00, 1'b1, 4'b0000};
        vecs[10] = '{4'b1110, 4'b0000, 4'b0001, 1'b1, 1'b1, 2'd0, 2'b10, 1'b1, 4'b0000};
        vecs[11] = '{4'b1110, 4'b0000, 4'b0001, 1'b1, 1'b0, 2'd0, 2'b10, 1'b0, 4'b0000};
        vecs[12] = '{4'b1010, 4'b0100, 4'b0001, 1'b1, 1'b0, 2'd0, 2'b10, 1'b1, 4'b0000};
        vecs[13] = '{4'b1010, 4'b0100, 4'b0001, 1'b0, 1'b1, 2'd2, 2'b01, 1'b1, 4'b0000};

        Reset = 1'b1; Red = '0; Green = '0; Blue = '0; Out_Ready = 1'b0;
        tick();
        tick();
        chk_port("reset", 1'b0, 2'd0, 2'b11, 1'b0, 4'b0000);
`ifdef COLOR_DROP_CNT_EN
        chk("reset drop_count", 32'(Drop_Count), 32'd0);
`endif
        Reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            Red = vecs[i].red; Green = vecs[i].green; Blue = vecs[i].blue;
            Out_Ready = vecs[i].rdy;
            tick();
            chk_port($sformatf("vec%0d", i), vecs[i].valid, vecs[i].chan,
                     vecs[i].color, vecs[i].busy, vecs[i].ovr);
        end

        // Offer of ch2 must hold steady under back-pressure.
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("hold%0d valid", c), 32'(Out_Valid), 32'd1);
            chk($sformatf("hold%0d chan", c), 32'(Out_Chan), 32'd2);
            chk($sformatf("hold%0d color", c), 32'(Out_Color), 32'b01);
        end

        // ch0 goes Red, then Green while its Red event still waits: only Green survives.
        Red = 4'b1011; Green = 4'b0100; Blue = 4'b0000;
        tick();
        chk_port("ovr_red", 1'b1, 2'd2, 2'b01, 1'b1, 4'b0000);
        Red = 4'b1010; Green = 4'b0101;
        tick();
        chk_port("ovr_green", 1'b1, 2'd2, 2'b01, 1'b1, 4'b0001);
        Out_Ready = 1'b1;
        tick();
        chk_port("ovr_accept", 1'b0, 2'd2, 2'b01, 1'b1, 4'b0001);
        tick();
        chk_port("ovr_deliver", 1'b1, 2'd0, 2'b01, 1'b1, 4'b0001);
        tick();
        chk_port("ovr_done", 1'b0, 2'd0, 2'b01, 1'b0, 4'b0001);
`ifdef COLOR_DROP_CNT_EN
        chk("drop_count", 32'(Drop_Count), 32'd1);
`endif

        // ch1 -> White and ch3 -> Blue together, then reset lands mid-offer of ch1.
        Red = 4'b0000; Green = 4'b0101; Blue = 4'b1000; Out_Ready = 1'b0;
        tick();
        chk_port("rst_queue", 1'b0, 2'd0, 2'b01, 1'b1, 4'b0001);
        tick();
        chk_port("rst_offer", 1'b1, 2'd1, 2'b11, 1'b1, 4'b0001);
        #2 Reset = 1'b1;
        #1;
        chk_port("rst_async", 1'b0, 2'd0, 2'b11, 1'b0, 4'b0000);
        Red = '0; Green = '0; Blue = '0; Out_Ready = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk_port($sformatf("post_rst%0d", c), 1'b0, 2'd0, 2'b11, 1'b0, 4'b0000);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
